// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_chunk_adder
// Description : Multi-cycle adder/subtractor. Processes two WIDTH-bit operands
//               DIGIT bits per clock, least-significant chunk first, with the
//               carry held in a register between chunks. Valid/ready
//               handshakes are used on both the operand and result sides.
//               Reports the sum, carry/borrow-out, signed overflow and zero.
// Ports       : clk, rst_n (async, active-low), ena (clock enable)
//               in_valid/in_ready, a, b, sub, cin         - operand side
//               out_valid/out_ready, sum, cout, ovf, zero - result side
// Revision    : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2     // must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_NCHUNK = WIDTH / DIGIT;
    localparam int c_CW     = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Operands are shifted right by DIGIT each RUN cycle so the active chunk
    // is always in the low DIGIT bits. On the final chunk the low chunk holds
    // the original top chunk, so bit DIGIT-1 is the operand's sign bit.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;        // already inverted for subtraction
    logic              r_sub;
    logic              r_carry;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_acc;      // working result, filled from the top down
    logic [WIDTH-1:0]  r_sum;      // published result, only updated on completion
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic [DIGIT:0]    w_chunk;
    logic [WIDTH-1:0]  w_acc_next;
    logic              w_last;

    assign w_chunk    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                      + (DIGIT+1)'(r_carry);
    // New chunk enters at the top; after NCHUNK shifts chunk 0 sits at bit 0.
    assign w_acc_next = WIDTH'({w_chunk[DIGIT-1:0], r_acc} >> DIGIT);
    assign w_last     = (r_cnt == c_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (ena) begin
            if (r_state == S_IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_sub   <= sub;
                // Subtraction is A + ~B + 1 - borrow_in, so the carry seed
                // is the inverted borrow.
                r_carry <= cin ^ sub;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> DIGIT;
                r_b     <= r_b >> DIGIT;
                r_acc   <= w_acc_next;
                r_carry <= w_chunk[DIGIT];
                r_cnt   <= r_cnt + c_CW'(1);
                if (w_last) begin
                    r_sum  <= w_acc_next;
                    // Borrow-out is the complement of the final carry.
                    r_cout <= r_sub ^ w_chunk[DIGIT];
                    r_ovf  <= (r_a[DIGIT-1] == r_b[DIGIT-1])
                           && (w_chunk[DIGIT-1] != r_a[DIGIT-1]);
                    r_zero <= (w_acc_next == '0);
                end
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_chunk_adder
// Description : Self-checking bench for serial_chunk_adder. Three instances
//               (DIGIT = 2, 1, 8 at WIDTH = 8) share stimulus; directed
//               vectors with hand-computed results plus handshake, pause and
//               reset sequences on the DIGIT = 2 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_adder;

    logic       clk = 1'b0;
    logic       rst_n, ena, in_valid, out_ready, sub, cin;
    logic [7:0] a, b;
    logic [2:0] ir, ov, co, of, zr;
    logic [7:0] sm [3];

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(8), .DIGIT(2)) u_dut_d2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
        .sum(sm[0]), .cout(co[0]), .ovf(of[0]), .zero(zr[0]));

    serial_chunk_adder #(.WIDTH(8), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
        .sum(sm[1]), .cout(co[1]), .ovf(of[1]), .zero(zr[1]));

    serial_chunk_adder #(.WIDTH(8), .DIGIT(8)) u_dut_d8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(ir[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
        .sum(sm[2]), .cout(co[2]), .ovf(of[2]), .zero(zr[2]));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] s;
        logic       c;
        logic       o;
        logic       z;
    } vec_t;

    vec_t vecs [10];
    int   lat_exp [3];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(&ir) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("all_idle", {29'd0, ir}, 32'd7);
    endtask

    task automatic run_op(input int idx);
        int         lat [3];
        logic [7:0] rs  [3];
        logic [2:0] rc, ro, rz;
        rc = '0; ro = '0; rz = '0;
        wait_idle();
        a = vecs[idx].a; b = vecs[idx].b; sub = vecs[idx].sub; cin = vecs[idx].cin;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~a;  b = ~b;  // operands may change after acceptance
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            rs[i]  = 8'h00;
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (lat[i] < 0 && ov[i]) begin
                    lat[i] = k;
                    rs[i]  = sm[i];
                    rc[i]  = co[i];
                    ro[i]  = of[i];
                    rz[i]  = zr[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("v%0d_i%0d_latency", idx, i), lat[i], lat_exp[i]);
            check($sformatf("v%0d_i%0d_sum", idx, i), {24'd0, rs[i]}, {24'd0, vecs[idx].s});
            check($sformatf("v%0d_i%0d_cout", idx, i), {31'd0, rc[i]}, {31'd0, vecs[idx].c});
            check($sformatf("v%0d_i%0d_ovf", idx, i), {31'd0, ro[i]}, {31'd0, vecs[idx].o});
            check($sformatf("v%0d_i%0d_zero", idx, i), {31'd0, rz[i]}, {31'd0, vecs[idx].z});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] s;
        int         seen;

        //           a      b      sub   cin   sum    c     o     z
        vecs[0] = '{8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h42, 8'h42, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        lat_exp[0] = 4;
        lat_exp[1] = 8;
        lat_exp[2] = 1;

        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; sub = 1'b0; cin = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", {29'd0, ir}, 32'd7);
        check("rst_out_valid", {29'd0, ov}, 32'd0);
        check("rst_sum", {24'd0, sm[0]}, 32'd0);
        check("rst_flags", {29'd0, co[0], of[0], zr[0]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors on all three chunk widths
        for (int v = 0; v < 10; v++) run_op(v);

        // Reset after chunk 1 of an add; previous result had all flags set
        wait_idle();
        a = 8'h7F; b = 8'h01; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, ir[0]}, 32'd1);
        check("midrst_out_valid", {31'd0, ov[0]}, 32'd0);
        check("midrst_sum", {24'd0, sm[0]}, 32'd0);
        check("midrst_flags", {29'd0, co[0], of[0], zr[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        check("midrst_no_result", seen, 0);
        run_op(0);

        // Backpressure: result held for 3 cycles, pulsed in_valid ignored
        wait_idle();
        a = 8'h3C; b = 8'h25; sub = 1'b0; cin = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_early_valid", {31'd0, ov[0]}, 32'd0);
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid_k%0d", k), {31'd0, ov[0]}, 32'd1);
            check($sformatf("bp_sum_k%0d", k), {24'd0, sm[0]}, 32'h61);
            check($sformatf("bp_in_ready_k%0d", k), {31'd0, ir[0]}, 32'd0);
            if (k == 5) begin
                in_valid = 1'b1; a = 8'h11; b = 8'h11;
            end
            if (k == 6) begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("bp_release_valid", {31'd0, ov[0]}, 32'd0);
        check("bp_release_in_ready", {31'd0, ir[0]}, 32'd1);
        check("bp_release_sum_kept", {24'd0, sm[0]}, 32'h61);

        // Clock-enable pause of 2 cycles mid-RUN
        wait_idle();
        a = 8'h3C; b = 8'h25; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        s = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (lat < 0 && ov[0]) begin
                lat = k;
                s = sm[0];
            end
            if (k == 1) ena = 1'b0;
            if (k == 3) ena = 1'b1;
        end
        check("pause_latency", lat, 6);
        check("pause_sum", {24'd0, s}, 32'h61);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
